// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial pattern generator: state encoding,
// default pattern and counter sizing helper.
package seq_fsm_pkg;

    localparam logic [2:0] ST_IDLE_ENC  = 3'b000;
    localparam logic [2:0] ST_SHIFT_ENC = 3'b001;
    localparam logic [2:0] ST_PAR_ENC   = 3'b010;
    localparam logic [2:0] ST_GAP_ENC   = 3'b011;
    localparam logic [2:0] ST_DONE_ENC  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_PAR   = ST_PAR_ENC,
        ST_GAP   = ST_GAP_ENC,
        ST_DONE  = ST_DONE_ENC
    } seq_state_e;

    localparam int unsigned SEQ_DEF_PAT_W   = 5;
    localparam logic [4:0]  SEQ_DEF_PATTERN = 5'b11011;

    // Counter width able to hold values 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register; zeros shift in at the LSB.
module seq_shift_reg #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic         o_msb
);

    logic [W-1:0] r_q;

    // Load has priority over shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends the pattern register MSB-first,
// (rep+1) times, separated by GAP_CYC idle-low cycles.
// Optional feature macro: SEQ_GEN_PARITY_EN adds one even-parity bit after
// every pattern repetition.
module seq_pattern_gen
    import seq_fsm_pkg::*;
#(
    parameter int unsigned      PAT_W   = SEQ_DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_DEF_PATTERN),
    parameter int unsigned      GAP_CYC = 2,
    parameter int unsigned      REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W    = cnt_width(PAT_W);
    localparam int unsigned GAP_W    = cnt_width(GAP_CYC);
    localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    seq_state_e       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_start;
    logic             w_pat_end;
    logic             w_reload;
    logic             w_shift;
    logic             w_load;
    logic [PAT_W-1:0] w_src;
    logic [PAT_W-1:0] w_load_val;
    logic             w_first_bit;
    logic             w_msb;

    // Shift register holds the bits still to be sent after the current one
    always_comb begin
        w_start     = (r_state == ST_IDLE) && start;
        w_src       = w_start ? (pat_load ? pat_in : r_pat) : r_pat;
`ifdef SEQ_GEN_PARITY_EN
        w_pat_end   = (r_state == ST_PAR);
`else
        w_pat_end   = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
`endif
        w_reload    = ((r_state == ST_GAP) && (r_gap_cnt == '0)) ||
                      (w_pat_end && (r_rep_cnt != '0) && (GAP_CYC == 0));
        w_load      = w_start || w_reload;
        w_shift     = (r_state == ST_SHIFT) && (r_bit_cnt != '0);
        w_first_bit = w_src[PAT_W-1];
        w_load_val  = {w_src[PAT_W-2:0], 1'b0};
    end

    seq_shift_reg #(
        .W (PAT_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (w_load_val),
        .o_msb   (w_msb)
    );

    // FSM, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= PATTERN;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_rep_cnt <= '0;
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pat_load) begin
                        r_pat <= pat_in;
                    end
                    if (start) begin
                        r_state   <= ST_SHIFT;
                        r_out     <= w_first_bit;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= BIT_W'(PAT_W - 1);
                        r_rep_cnt <= rep;
                    end
                end
                ST_SHIFT: begin
                    if (r_bit_cnt != '0) begin
                        r_out     <= w_msb;
                        r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                    end
`ifdef SEQ_GEN_PARITY_EN
                    else begin
                        r_state <= ST_PAR;
                        r_out   <= ^r_pat;
                    end
`endif
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state   <= ST_SHIFT;
                        r_out     <= r_pat[PAT_W-1];
                        r_valid   <= 1'b1;
                        r_bit_cnt <= BIT_W'(PAT_W - 1);
                        r_rep_cnt <= r_rep_cnt - REP_W'(1);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            // End of one pattern (plus parity): finish, gap, or restart directly
            if (w_pat_end) begin
                if (r_rep_cnt == '0) begin
                    r_state <= ST_DONE;
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end else if (GAP_CYC == 0) begin
                    r_state   <= ST_SHIFT;
                    r_out     <= r_pat[PAT_W-1];
                    r_valid   <= 1'b1;
                    r_bit_cnt <= BIT_W'(PAT_W - 1);
                    r_rep_cnt <= r_rep_cnt - REP_W'(1);
                end else begin
                    r_state   <= ST_GAP;
                    r_out     <= 1'b0;
                    r_valid   <= 1'b0;
                    r_gap_cnt <= GAP_W'(GAP_LAST);
                end
            end
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
